// File: rtl/aura_q_pkg.sv
// Shared types and helpers for the Q-format alignment datapath.
// A Q(I,F) sample is a sign bit, I integer bits and F fractional bits.
package aura_q_pkg;

  typedef enum logic [1:0] {
    RM_TRUNC = 2'b00,
    RM_RHU   = 2'b01,
    RM_RNE   = 2'b10,
    RM_RSVD  = 2'b11
  } round_mode_e;

  function automatic int q_width(input int int_bits, input int frac_bits);
    return 1 + int_bits + frac_bits;
  endfunction

  // Common intermediate width: sign, widest integer part, output fraction,
  // plus one guard bit so a round-up never wraps.
  function automatic int q_wide_width(input int in_i, input int out_i, input int out_f);
    return 2 + ((in_i > out_i) ? in_i : out_i) + out_f;
  endfunction

  function automatic logic [63:0] q_out_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] q_out_min(input int width);
    return ~q_out_max(width);
  endfunction

endpackage

// File: rtl/q_round_lane.sv
// One lane of the converter: fraction alignment/rounding on the front port
// pair, saturation on the back pair, so a register can sit in between.
module q_round_lane
  import aura_q_pkg::*;
#(
  parameter int IN_I   = 4,
  parameter int IN_F   = 12,
  parameter int OUT_I  = 4,
  parameter int OUT_F  = 4,
  localparam int W_IN   = q_width(IN_I, IN_F),
  localparam int W_OUT  = q_width(OUT_I, OUT_F),
  localparam int W_WIDE = q_wide_width(IN_I, OUT_I, OUT_F)
) (
  input  logic [W_IN-1:0]   sample,
  input  round_mode_e       mode,
  output logic [W_WIDE-1:0] rounded,
  input  logic [W_WIDE-1:0] held,
  output logic [W_OUT-1:0]  result,
  output logic              sat
);

  if (OUT_F >= IN_F) begin : g_pad
    localparam int SL  = OUT_F - IN_F;
    localparam int EXT = W_WIDE - W_IN - SL;
    logic unused_mode;
    assign unused_mode = ^mode;
    if (SL == 0) begin : g_same
      assign rounded = {{EXT{sample[W_IN-1]}}, sample};
    end else begin : g_shift
      assign rounded = {{EXT{sample[W_IN-1]}}, sample, {SL{1'b0}}};
    end
  end else begin : g_round
    localparam int SH = IN_F - OUT_F;
    localparam int XW = W_WIDE + SH;
    logic [XW-1:0]     xw;
    logic [W_WIDE-1:0] fl;
    logic [SH-1:0]     frac;
    logic [SH-1:0]     frac_low;
    logic              half;
    logic              rest;
    logic              inc;

    assign xw       = {{(XW-W_IN){sample[W_IN-1]}}, sample};
    assign fl       = xw[XW-1:SH];
    assign frac     = xw[SH-1:0];
    // Dropping the half bit leaves only the sticky bits below it.
    assign frac_low = frac << 1;
    assign half     = frac[SH-1];
    assign rest     = |frac_low;

    always_comb begin
      inc = 1'b0;
      case (mode)
        RM_RHU:  inc = half;
        RM_RNE:  inc = half & (rest | fl[0]);
        default: inc = 1'b0;
      endcase
    end

    assign rounded = fl + {{(W_WIDE-1){1'b0}}, inc};
  end

  q_saturate #(
    .W_WIDE  (W_WIDE),
    .W_NARROW(W_OUT)
  ) u_sat (
    .wide  (held),
    .narrow(result),
    .sat   (sat)
  );

endmodule

// File: rtl/q_saturate.sv
// Clamps a sign-extended wide value into a narrower two's complement range,
// flagging any value that does not fit exactly.
module q_saturate
  import aura_q_pkg::*;
#(
  parameter int W_WIDE   = 10,
  parameter int W_NARROW = 9
) (
  input  logic [W_WIDE-1:0]   wide,
  output logic [W_NARROW-1:0] narrow,
  output logic                sat
);

  localparam logic [63:0] MAX64 = q_out_max(W_NARROW);
  localparam logic [63:0] MIN64 = q_out_min(W_NARROW);

  logic fits;

  // Representable iff every bit above the narrow sign bit copies the sign.
  assign fits = (wide[W_WIDE-1:W_NARROW-1] == {(W_WIDE-W_NARROW+1){wide[W_WIDE-1]}});

  always_comb begin
    sat = !fits;
    if (fits) begin
      narrow = wide[W_NARROW-1:0];
    end else if (wide[W_WIDE-1]) begin
      narrow = MIN64[W_NARROW-1:0];
    end else begin
      narrow = MAX64[W_NARROW-1:0];
    end
  end

endmodule

// File: rtl/q_align_stream.sv
// Multi-lane Q-format converter with a two-stage valid/ready pipeline.
// Saturation statistics are built only when Q_ALIGN_SAT_STATS_EN is defined.
module q_align_stream
  import aura_q_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int IN_I    = 4,
  parameter int IN_F    = 12,
  parameter int OUT_I   = 4,
  parameter int OUT_F   = 4,
  parameter int CNT_W   = 16,
  localparam int W_IN   = q_width(IN_I, IN_F),
  localparam int W_OUT  = q_width(OUT_I, OUT_F)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LANES*W_IN-1:0]    in_data,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LANES*W_OUT-1:0]   out_data,
  output logic [N_LANES-1:0]         out_sat,
  input  logic                       clear_stats,
  output logic                       sat_sticky,
  output logic [CNT_W-1:0]           sat_count
);

  localparam int W_WIDE = q_wide_width(IN_I, OUT_I, OUT_F);

  logic                     adv;
  logic                     s1_valid;
  logic [W_WIDE-1:0]        s1_value [N_LANES];
  logic [W_WIDE-1:0]        rounded  [N_LANES];
  logic [N_LANES*W_OUT-1:0] sat_data;
  logic [N_LANES-1:0]       sat_flags;

  // One enable for the whole pipe: it moves whenever the output slot frees.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    q_round_lane #(
      .IN_I (IN_I),
      .IN_F (IN_F),
      .OUT_I(OUT_I),
      .OUT_F(OUT_F)
    ) u_lane (
      .sample (in_data[gi*W_IN +: W_IN]),
      .mode   (round_mode_e'(in_mode)),
      .rounded(rounded[gi]),
      .held   (s1_value[gi]),
      .result (sat_data[gi*W_OUT +: W_OUT]),
      .sat    (sat_flags[gi])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        s1_value[i] <= '0;
      end
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_value  <= rounded;
      out_valid <= s1_valid;
      out_data  <= sat_data;
      out_sat   <= s1_valid ? sat_flags : '0;
    end
  end

`ifdef Q_ALIGN_SAT_STATS_EN
  logic [CNT_W-1:0] count;
  logic             sticky;

  // Clear has priority over a same-cycle saturating handoff.
  always_ff @(posedge clock) begin
    if (!reset_n || clear_stats) begin
      count  <= '0;
      sticky <= 1'b0;
    end else if (out_valid && out_ready && (|out_sat)) begin
      sticky <= 1'b1;
      if (count != {CNT_W{1'b1}}) begin
        count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign sat_count  = count;
  assign sat_sticky = sticky;
`else
  logic unused_clear;
  assign unused_clear = clear_stats;
  assign sat_count    = '0;
  assign sat_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_q_align_stream.sv
// Self-checking bench for q_align_stream: hand-computed vector table, stall,
// saturation-statistics and reset sequences, then randomized traffic.
module tb_q_align_stream;

  localparam int N_LANES = 4;
  localparam int IN_I    = 6;
  localparam int IN_F    = 12;
  localparam int OUT_I   = 4;
  localparam int OUT_F   = 4;
  localparam int CNT_W   = 4;
  localparam int W_IN    = 1 + IN_I + IN_F;
  localparam int W_OUT   = 1 + OUT_I + OUT_F;
  localparam int DW_IN   = N_LANES * W_IN;
  localparam int DW_OUT  = N_LANES * W_OUT;
  localparam longint SCALE = 256;
  localparam longint OMAX  = 255;
  localparam longint OMIN  = -256;
  localparam longint CMAX  = 15;
`ifdef Q_ALIGN_SAT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW_IN-1:0]  in_data;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DW_OUT-1:0] out_data;
  logic [N_LANES-1:0] out_sat;
  logic              clear_stats;
  logic              sat_sticky;
  logic [CNT_W-1:0]  sat_count;

  q_align_stream #(
    .N_LANES(N_LANES), .IN_I(IN_I), .IN_F(IN_F),
    .OUT_I(OUT_I), .OUT_F(OUT_F), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .clear_stats(clear_stats), .sat_sticky(sat_sticky), .sat_count(sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model (value arithmetic) ----------------
  function automatic longint ref_lane(input longint x, input logic [1:0] m, output bit sat);
    longint fl, rem;
    fl  = (x >= 0) ? x / SCALE : -((-x + SCALE - 1) / SCALE);
    rem = x - fl * SCALE;
    if (m == 2'b01 && 2 * rem >= SCALE) fl++;
    else if (m == 2'b10 && (2 * rem > SCALE || (2 * rem == SCALE && (fl % 2) != 0))) fl++;
    sat = 1'b0;
    if (fl > OMAX) begin fl = OMAX; sat = 1'b1; end
    else if (fl < OMIN) begin fl = OMIN; sat = 1'b1; end
    return fl;
  endfunction

  typedef struct packed {
    logic [DW_OUT-1:0]  data;
    logic [N_LANES-1:0] sat;
  } exp_t;

  function automatic exp_t ref_beat(input logic [DW_IN-1:0] din, input logic [1:0] m);
    exp_t e;
    logic signed [W_IN-1:0] s;
    longint x, r;
    logic [63:0] rb;
    bit sf;
    for (int k = 0; k < N_LANES; k++) begin
      s  = din[k*W_IN +: W_IN];
      x  = s;
      r  = ref_lane(x, m, sf);
      rb = r;
      e.data[k*W_OUT +: W_OUT] = rb[W_OUT-1:0];
      e.sat[k] = sf;
    end
    return e;
  endfunction

  function automatic logic [DW_IN-1:0] pack_in(input longint a, input longint b,
                                                input longint c, input longint d);
    logic [DW_IN-1:0] v;
    longint arr [N_LANES];
    logic [63:0] t;
    arr = '{a, b, c, d};
    for (int k = 0; k < N_LANES; k++) begin
      t = arr[k];
      v[k*W_IN +: W_IN] = t[W_IN-1:0];
    end
    return v;
  endfunction

  function automatic logic [DW_OUT-1:0] pack_out(input longint a, input longint b,
                                                  input longint c, input longint d);
    logic [DW_OUT-1:0] v;
    longint arr [N_LANES];
    logic [63:0] t;
    arr = '{a, b, c, d};
    for (int k = 0; k < N_LANES; k++) begin
      t = arr[k];
      v[k*W_OUT +: W_OUT] = t[W_OUT-1:0];
    end
    return v;
  endfunction

  function automatic longint rand_lane();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return longint'($urandom_range(0, 524287)) - 262144;
    if (sel == 1) return (longint'($urandom_range(0, 8000)) - 4000) * 128;
    return longint'($urandom_range(0, 139264)) - 69632;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  exp_t              sb_q [$];
  bit                mon_en = 1'b0;
  longint            m_count = 0;
  bit                m_sticky = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DW_OUT-1:0] prev_data;
  logic [N_LANES-1:0] prev_sat;
  int                n_out = 0;

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      chk("sat_count", 64'(sat_count), STATS ? 64'(m_count) : 64'd0);
      chk("sat_sticky", 64'(sat_sticky), STATS ? 64'(m_sticky) : 64'd0);
      if (!reset_n) begin
        sb_q.delete();
        m_count    = 0;
        m_sticky   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", 64'(out_data), 64'(prev_data));
          chk("stall_sat", 64'(out_sat), 64'(prev_sat));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            timeout("unexpected_beat");
          end else begin
            e = sb_q.pop_front();
            $display("beat %0d out_data=%h out_sat=%b", n_out, out_data, out_sat);
            n_out++;
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_sat", 64'(out_sat), 64'(e.sat));
            if (|e.sat) begin
              if (m_count < CMAX) m_count++;
              m_sticky = 1'b1;
            end
          end
        end
        if (clear_stats) begin
          m_count  = 0;
          m_sticky = 1'b0;
        end
        if (in_valid && in_ready) sb_q.push_back(ref_beat(in_data, in_mode));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_sat   = out_sat;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [DW_IN-1:0] d, input logic [1:0] m);
    bit acc;
    int guard;
    guard    = 0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) timeout("send");
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 200) timeout("drain");
  endtask

  typedef struct packed {
    logic [DW_IN-1:0]   din;
    logic [1:0]         mode;
    logic [DW_OUT-1:0]  dout;
    logic [N_LANES-1:0] sat;
  } vec_t;

  vec_t vecs [11];
  logic [DW_IN-1:0] stream [8];
  logic [1:0]       stream_mode [8];

  initial begin
    int sent, got, stall_seen, guard;
    logic [DW_IN-1:0] sat_beat;

    // Values in input LSBs (2^-12); expectations in output LSBs (2^-4).
    vecs[0]  = '{pack_in(6272, 0, 0, 0), 2'b00, pack_out(24, 0, 0, 0), 4'b0000};
    vecs[1]  = '{pack_in(6272, 0, 0, 0), 2'b01, pack_out(25, 0, 0, 0), 4'b0000};
    vecs[2]  = '{pack_in(6272, 0, 0, 0), 2'b10, pack_out(24, 0, 0, 0), 4'b0000};
    vecs[3]  = '{pack_in(-128, 0, 0, 0), 2'b00, pack_out(-1, 0, 0, 0), 4'b0000};
    vecs[4]  = '{pack_in(-128, 0, 0, 0), 2'b01, pack_out(0, 0, 0, 0), 4'b0000};
    vecs[5]  = '{pack_in(-128, 0, 0, 0), 2'b10, pack_out(0, 0, 0, 0), 4'b0000};
    vecs[6]  = '{pack_in(-128, 0, 0, 0), 2'b11, pack_out(-1, 0, 0, 0), 4'b0000};
    vecs[7]  = '{pack_in(81920, -81920, 65408, 0), 2'b01, pack_out(255, -256, 255, 0), 4'b0111};
    vecs[8]  = '{pack_in(65280, -65536, 6528, -6272), 2'b00, pack_out(255, -256, 25, -25), 4'b0000};
    vecs[9]  = '{pack_in(65280, -65536, 6528, -6272), 2'b10, pack_out(255, -256, 26, -24), 4'b0000};
    vecs[10] = '{pack_in(65280, -65536, 6528, -6272), 2'b01, pack_out(255, -256, 26, -24), 4'b0000};
    sat_beat = pack_in(81920, 0, 0, 0);

    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00;
    out_ready = 1'b1; clear_stats = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_sat_sticky", 64'(sat_sticky), 64'd0);
    mon_en = 1'b1;

    // Table: one beat at a time, checking two-cycle latency and values.
    for (int i = 0; i < 11; i++) begin
      in_data = vecs[i].din; in_mode = vecs[i].mode; in_valid = 1'b1;
      chk("tab_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("tab_lat_early", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      chk("tab_lat_valid", 64'(out_valid), 64'd1);
      chk("tab_data", 64'(out_data), 64'(vecs[i].dout));
      chk("tab_sat", 64'(out_sat), 64'(vecs[i].sat));
      @(posedge clock); #1;
    end
    chk("tab_count", 64'(sat_count), STATS ? 64'd1 : 64'd0);
    chk("tab_sticky", 64'(sat_sticky), STATS ? 64'd1 : 64'd0);

    // Eight-beat stream with out_ready low in cycles 3..5.
    for (int i = 0; i < 8; i++) begin
      stream[i] = pack_in(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      stream_mode[i] = 2'($urandom_range(0, 3));
    end
    sent = 0; got = 0; stall_seen = 0; guard = 0;
    while ((sent < 8 || got < 8) && guard < 100) begin
      out_ready = !(guard >= 3 && guard <= 5);
      in_valid  = (sent < 8);
      in_data   = stream[sent % 8];
      in_mode   = stream_mode[sent % 8];
      @(negedge clock);
      if (out_valid && !out_ready) begin
        stall_seen++;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) got++;
      @(posedge clock); #1;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (guard >= 100) timeout("stream");
    chk("stream_got", 64'(got), 64'd8);
    chk("stream_stalls", 64'(stall_seen), 64'd3);
    wait_empty();

    // Count saturates at all-ones.
    clear_stats = 1'b1;
    @(posedge clock); #1;
    clear_stats = 1'b0;
    for (int i = 0; i < 17; i++) send(sat_beat, 2'b00);
    wait_empty();
    chk("count_hold", 64'(sat_count), STATS ? 64'(CMAX) : 64'd0);
    chk("count_sticky", 64'(sat_sticky), STATS ? 64'd1 : 64'd0);

    // Clear in the same cycle as a saturating handoff.
    out_ready = 1'b0;
    send(sat_beat, 2'b00);
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!out_valid) timeout("clear_setup");
    chk("clear_pre_count", 64'(sat_count), STATS ? 64'(CMAX) : 64'd0);
    clear_stats = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    clear_stats = 1'b0;
    chk("clear_wins_count", 64'(sat_count), 64'd0);
    chk("clear_wins_sticky", 64'(sat_sticky), 64'd0);

    // Reset with two beats in flight.
    send(sat_beat, 2'b01);
    wait_empty();
    chk("pre_rst_count", 64'(sat_count), STATS ? 64'd1 : 64'd0);
    send(sat_beat, 2'b00);
    send(pack_in(6272, 0, 0, 0), 2'b01);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_count", 64'(sat_count), 64'd0);
    chk("mid_rst_sticky", 64'(sat_sticky), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = pack_in(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      in_mode     = 2'($urandom_range(0, 3));
      out_ready   = ($urandom_range(0, 9) < 7);
      clear_stats = ($urandom_range(0, 29) == 0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
    wait_empty();
    @(posedge clock); #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
